// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Sequences fixed-latency accesses to the shared data memory and
//            grants it round-robin between the CPU MEM stage and the
//            debug/loader port. Stalls the pipeline until the CPU access
//            completes and keeps a saturating stall-cycle count.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [15:0]       stall_cnt_o
);

  // Latency counter must hold MEM_LAT-1 for MEM_LAT up to 15.
  localparam int          LAT_W    = 4;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  // Owner / last-grant encoding.
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [DATA_W-1:0]  dbg_rdata_q, dbg_rdata_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;
  logic               grant_dbg;
  logic               dbg_read_done;

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_DBG;
      lat_cnt_q    <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      dbg_rdata_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lat_cnt_q    <= lat_cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Next-state logic: grant in IDLE, count down in BUSY, one-cycle DONE.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lat_cnt_d    = lat_cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    // Debug wins when alone, or on a tie when the CPU had the last grant.
    grant_dbg    = dbg_req_i && (!cpu_req_i || (last_grant_q == OWN_CPU));
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i || dbg_req_i) begin
          owner_d      = grant_dbg;
          last_grant_d = grant_dbg;
          we_d         = grant_dbg ? dbg_we_i    : cpu_we_i;
          addr_d       = grant_dbg ? dbg_addr_i  : cpu_addr_i;
          wdata_d      = grant_dbg ? dbg_wdata_i : cpu_wdata_i;
          lat_cnt_d    = LAT_INIT;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (lat_cnt_q == '0) begin
          if (!we_q) begin
            rdata_d = mem_rdata_i;
          end
          state_d = S_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (dbg_read_done) begin
          dbg_rdata_d = rdata_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cpu_stall_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // A debug read delivers its data in the DONE cycle together with the ack
  // and the register holds it afterwards.
  assign dbg_read_done = (state_q == S_DONE) && (owner_q == OWN_DBG) && !we_q;

  assign cpu_stall_o = cpu_req_i && !((state_q == S_DONE) && (owner_q == OWN_CPU));
  assign cpu_rdata_o = rdata_q;
  assign dbg_rdata_o = dbg_read_done ? rdata_q : dbg_rdata_q;
  assign dbg_ack_o   = (state_q == S_DONE) && (owner_q == OWN_DBG);
  assign mem_en_o    = (state_q == S_BUSY);
  assign mem_we_o    = (state_q == S_BUSY) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter (MEM_LAT = 2).
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int MEM_LAT = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic              clk;
  logic              start_i;
  logic              cpu_req_i, cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i, cpu_rdata_o;
  logic              cpu_stall_o;
  logic              dbg_req_i, dbg_we_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i, dbg_rdata_o;
  logic              dbg_ack_o;
  logic              mem_en_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;
  logic [15:0]       stall_cnt_o;

  int checks = 0;
  int errors = 0;

  // Word-addressed memory model standing in for the data RAM.
  logic [DATA_W-1:0] mem [0:63];

  dmem_arbiter #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .start_i(start_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata_i = mem[mem_addr_o[7:2]];
  always @(posedge clk) if (mem_en_o && mem_we_o) mem[mem_addr_o[7:2]] <= mem_wdata_o;

  // Advance to just after the next rising edge.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with no requests, then release.
  task automatic reset_dut;
    start_i = 1'b0; cpu_req_i = 1'b0; dbg_req_i = 1'b0;
    next_cycle();
    next_cycle();
    start_i = 1'b1;
  endtask

  task automatic test_reset;
    start_i = 1'b0; cpu_req_i = 1'b0; dbg_req_i = 1'b0;
    next_cycle();
    checks++; if ({mem_en_o, mem_we_o, dbg_ack_o, cpu_stall_o} !== 4'b0000) begin errors++; $display("FAIL rst_ctrl got %b exp 0000", {mem_en_o, mem_we_o, dbg_ack_o, cpu_stall_o}); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", mem_addr_o); end
    checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", mem_wdata_o); end
    checks++; if ({cpu_rdata_o, dbg_rdata_o} !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", {cpu_rdata_o, dbg_rdata_o}); end
    checks++; if (stall_cnt_o !== 16'h0) begin errors++; $display("FAIL rst_stall_cnt got %h exp 0", stall_cnt_o); end
    cpu_req_i = 1'b1;
    #1;
    checks++; if (cpu_stall_o !== 1'b1) begin errors++; $display("FAIL rst_stall_follows got %b exp 1", cpu_stall_o); end
    next_cycle();
    next_cycle();
    checks++; if ({stall_cnt_o, mem_en_o} !== 17'h0) begin errors++; $display("FAIL rst_hold got %h exp 0", {stall_cnt_o, mem_en_o}); end
    cpu_req_i = 1'b0;
    start_i = 1'b1;
    for (int k = 0; k < 5; k++) next_cycle();
    checks++; if (stall_cnt_o !== 16'h0) begin errors++; $display("FAIL idle_stall_cnt got %0d exp 0", stall_cnt_o); end
  endtask

  task automatic test_cpu_load;
    logic [3:0] st, en;
    reset_dut();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      st[k] = cpu_stall_o; en[k] = mem_en_o;
      if (k == 3) begin
        checks++; if (cpu_rdata_o !== 32'd5) begin errors++; $display("FAIL load_rdata got %h exp 5", cpu_rdata_o); end
      end
      next_cycle();
    end
    cpu_req_i = 1'b0;
    @(negedge clk);
    checks++; if (st !== 4'b0111) begin errors++; $display("FAIL load_stall got %b exp 0111", st); end
    checks++; if (en !== 4'b0110) begin errors++; $display("FAIL load_en got %b exp 0110", en); end
    checks++; if (stall_cnt_o !== 16'd3) begin errors++; $display("FAIL load_stall_cnt got %0d exp 3", stall_cnt_o); end
    next_cycle();
  endtask

  task automatic test_contend;
    logic [8:0] st, ack, en;
    reset_dut();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h4;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h8;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      st[k] = cpu_stall_o; ack[k] = dbg_ack_o; en[k] = mem_en_o;
      if (k == 3) begin
        checks++; if (cpu_rdata_o !== 32'h11) begin errors++; $display("FAIL cont_cpu_rdata got %h exp 11", cpu_rdata_o); end
      end
      if (k == 5) begin
        checks++; if (mem_addr_o !== 32'h8) begin errors++; $display("FAIL cont_dbg_addr got %h exp 8", mem_addr_o); end
      end
      if (k == 7 || k == 8) begin
        checks++; if (dbg_rdata_o !== 32'h22) begin errors++; $display("FAIL cont_dbg_rdata c%0d got %h exp 22", k, dbg_rdata_o); end
      end
      next_cycle();
      if (k == 3) cpu_req_i = 1'b0;
      if (k == 7) dbg_req_i = 1'b0;
    end
    checks++; if (st !== 9'b000000111) begin errors++; $display("FAIL cont_stall got %b exp 000000111", st); end
    checks++; if (ack !== 9'b010000000) begin errors++; $display("FAIL cont_ack got %b exp 010000000", ack); end
    checks++; if (en !== 9'b001100110) begin errors++; $display("FAIL cont_en got %b exp 001100110", en); end
    checks++; if (stall_cnt_o !== 16'd3) begin errors++; $display("FAIL cont_stall_cnt got %0d exp 3", stall_cnt_o); end
  endtask

  // Runs straight after test_contend, so dbg_rdata_o still holds 0x22.
  task automatic test_dbg_write;
    logic [4:0] ack;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h1c; dbg_wdata_i = 32'hDEADBEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ack[k] = dbg_ack_o;
      if (k == 1 || k == 2) begin
        checks++; if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, 32'h1c, 32'hDEADBEEF})
          begin errors++; $display("FAIL wr_bus c%0d got %b %b %h %h exp 1 1 0000001c deadbeef", k, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o); end
      end
      if (k >= 3) begin
        checks++; if (dbg_rdata_o !== 32'h22) begin errors++; $display("FAIL wr_dbg_rdata c%0d got %h exp 22", k, dbg_rdata_o); end
      end
      next_cycle();
      if (k == 0) dbg_req_i = 1'b0;
    end
    dbg_we_i = 1'b0;
    checks++; if (ack !== 5'b01000) begin errors++; $display("FAIL wr_ack got %b exp 01000", ack); end
    checks++; if (mem[7] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem got %h exp deadbeef", mem[7]); end
  endtask

  task automatic test_round_robin;
    logic [15:0] en, ack;
    logic [31:0] ba [4];
    reset_dut();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h4;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      en[k] = mem_en_o; ack[k] = dbg_ack_o;
      if ((k % 4) == 1) ba[k/4] = mem_addr_o;
      next_cycle();
    end
    cpu_req_i = 1'b0; dbg_req_i = 1'b0;
    @(negedge clk);
    checks++; if (en !== 16'h6666) begin errors++; $display("FAIL rr_en got %h exp 6666", en); end
    checks++; if (ack !== 16'h8080) begin errors++; $display("FAIL rr_ack got %h exp 8080", ack); end
    checks++; if ({ba[0], ba[1], ba[2], ba[3]} !== {32'h0, 32'h4, 32'h0, 32'h4})
      begin errors++; $display("FAIL rr_order got %h %h %h %h exp 0 4 0 4", ba[0], ba[1], ba[2], ba[3]); end
    checks++; if (stall_cnt_o !== 16'd14) begin errors++; $display("FAIL rr_stall_cnt got %0d exp 14", stall_cnt_o); end
    next_cycle();
  endtask

  task automatic test_reset_abort;
    logic [3:0] ack;
    reset_dut();
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h8;
    next_cycle();
    checks++; if (mem_en_o !== 1'b1) begin errors++; $display("FAIL ab_busy got %b exp 1", mem_en_o); end
    #2;
    start_i = 1'b0;
    #1;
    checks++; if ({mem_en_o, dbg_ack_o} !== 2'b00) begin errors++; $display("FAIL ab_immediate got %b exp 00", {mem_en_o, dbg_ack_o}); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ack[k] = dbg_ack_o;
      checks++; if (dbg_rdata_o !== 32'h0) begin errors++; $display("FAIL ab_rdata c%0d got %h exp 0", k, dbg_rdata_o); end
      next_cycle();
    end
    start_i = 1'b1;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ack[k+2] = dbg_ack_o;
      if (k == 1) begin
        checks++; if ({mem_en_o, mem_addr_o} !== {1'b1, 32'h10}) begin errors++; $display("FAIL ab_cpu_first got %b %h exp 1 00000010", mem_en_o, mem_addr_o); end
      end
      next_cycle();
    end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL ab_no_ack got %b exp 0000", ack); end
    cpu_req_i = 1'b0; dbg_req_i = 1'b0;
    for (int k = 0; k < 4; k++) next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'd5; mem[1] = 32'h11; mem[2] = 32'h22; mem[4] = 32'h44;
    start_i = 1'b0;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    test_reset();
    test_cpu_load();
    test_contend();
    test_dbg_write();
    test_round_robin();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
`default_nettype wire
